fft_io_sequencer: RTL and testbench

Control sequencer for the FFT external I/O stage. It drives that stage's chip-select, read/write and tristate controls, and the frame buffer memory port.
- Load: moves one NUM_POINTS-word frame from the host bus into the frame buffer.
- Unload: streams a transformed frame from the frame buffer out to the host bus.
- Sits directly upstream of the I/O stage (generates all its c_* controls) and beside the frame buffer RAM (1-cycle synchronous read).

---
 rtl/fft_io_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_fft_io_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_io_sequencer.sv
// fft_io_sequencer
//   Control sequencer for the FFT external I/O stage. Loads one NUM_POINTS-word
//   frame from the host bus into the frame buffer, or streams a transformed
//   frame from the frame buffer back out to the host bus. No data passes
//   through this block; it only generates the I/O stage controls (c_*) and
//   the frame buffer port (1-cycle synchronous read).
//
// Ports
//   io_clock             sole clock, rising edge
//   reset                asynchronous, active-low
//   start_load           1-cycle request: begin frame load
//   start_unload         1-cycle request: begin frame unload
//   ext_valid            host drives a valid word this cycle (load only)
//   ext_strobe           external port carries a valid output word (unload)
//   ext_dir              1 = block drives external port
//   busy                 high in any non-IDLE state
//   load_done            pulse with the final load write
//   unload_done          pulse in the cycle after the final output word
//   cmd_err              pulse, start request rejected
//   c_chip_select        I/O stage chip select
//   c_ext_write          I/O stage direction, 1 = internal->external
//   c_tri_data_2b_input  0 = I/O stage drives internal bus
//   c_tri_data_2b_output 0 = I/O stage drives external port
//   mem_addr             frame buffer address
//   mem_we               frame buffer write enable
//   mem_re               frame buffer read enable (data valid next cycle)
module fft_io_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_POINTS = 64
) (
  input  logic                  io_clock,
  input  logic                  reset,
  input  logic                  start_load,
  input  logic                  start_unload,
  input  logic                  ext_valid,
  output logic                  ext_strobe,
  output logic                  ext_dir,
  output logic                  busy,
  output logic                  load_done,
  output logic                  unload_done,
  output logic                  cmd_err,
  output logic                  c_chip_select,
  output logic                  c_ext_write,
  output logic                  c_tri_data_2b_input,
  output logic                  c_tri_data_2b_output,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic                  mem_re
);

  // A misconfigured instance never leaves IDLE rather than mis-addressing.
  localparam bit CFG_OK = (DATA_WIDTH > 0) && (NUM_POINTS >= 2) &&
                          (NUM_POINTS <= (2 ** ADDR_WIDTH));

  localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH + 1)'(NUM_POINTS - 1);
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(NUM_POINTS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LOAD_DRAIN,
    S_UNLOAD,
    S_UNLOAD_DRAIN
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH:0]   r_cnt;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_mem_we;
  logic                  r_mem_re;
  logic                  r_cs_unl;
  logic                  r_strobe;
  logic                  r_dir;
  logic                  r_busy;
  logic                  r_load_done;
  logic                  r_unload_done;
  logic                  r_cmd_err;

  logic                  w_accept;
  logic                  w_any_start;

  // The I/O stage captures the host word at the end of an accepting cycle,
  // so load chip-select must follow ext_valid within the same cycle.
  assign w_accept    = (r_state == S_LOAD) && ext_valid;
  assign w_any_start = start_load || start_unload;

  always_ff @(posedge io_clock or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_mem_addr    <= '0;
      r_mem_we      <= 1'b0;
      r_mem_re      <= 1'b0;
      r_cs_unl      <= 1'b0;
      r_strobe      <= 1'b0;
      r_dir         <= 1'b0;
      r_busy        <= 1'b0;
      r_load_done   <= 1'b0;
      r_unload_done <= 1'b0;
      r_cmd_err     <= 1'b0;
    end else begin
      r_load_done   <= 1'b0;
      r_unload_done <= 1'b0;
      r_mem_we      <= 1'b0;
      r_cmd_err     <= 1'b0;
      // Unload pipeline: read at t, chip-select at t+1, strobe at t+2.
      r_cs_unl      <= r_mem_re;
      r_strobe      <= r_cs_unl;

      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (start_load && CFG_OK) begin
            r_state   <= S_LOAD;
            r_busy    <= 1'b1;
            r_cmd_err <= start_unload;
          end else if (start_unload && CFG_OK) begin
            r_state    <= S_UNLOAD;
            r_busy     <= 1'b1;
            r_dir      <= 1'b1;
            r_mem_re   <= 1'b1;
            r_mem_addr <= '0;
            r_cnt      <= (ADDR_WIDTH + 1)'(1);
          end
        end

        S_LOAD: begin
          r_cmd_err <= w_any_start;
          if (ext_valid) begin
            r_mem_we   <= 1'b1;
            r_mem_addr <= r_cnt[ADDR_WIDTH-1:0];
            r_cnt      <= r_cnt + 1'b1;
            if (r_cnt == LAST_IDX) begin
              r_state     <= S_LOAD_DRAIN;
              r_load_done <= 1'b1;
            end
          end
        end

        S_LOAD_DRAIN: begin
          r_cmd_err <= w_any_start;
          r_state   <= S_IDLE;
          r_busy    <= 1'b0;
        end

        S_UNLOAD: begin
          r_cmd_err <= w_any_start;
          if (r_cnt == FULL_CNT) begin
            r_mem_re <= 1'b0;
            r_state  <= S_UNLOAD_DRAIN;
            r_cnt    <= '0;
          end else begin
            r_mem_addr <= r_cnt[ADDR_WIDTH-1:0];
            r_cnt      <= r_cnt + 1'b1;
          end
        end

        S_UNLOAD_DRAIN: begin
          r_cmd_err <= w_any_start;
          if (r_cnt[0]) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_dir         <= 1'b0;
            r_unload_done <= 1'b1;
            r_cnt         <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_dir   <= 1'b0;
        end
      endcase
    end
  end

  assign ext_strobe           = r_strobe;
  assign ext_dir              = r_dir;
  assign busy                 = r_busy;
  assign load_done            = r_load_done;
  assign unload_done          = r_unload_done;
  assign cmd_err              = r_cmd_err;
  assign c_chip_select        = w_accept || r_cs_unl;
  assign c_ext_write          = r_dir;
  // The internal bus is driven exactly in write cycles.
  assign c_tri_data_2b_input  = ~r_mem_we;
  assign c_tri_data_2b_output = ~r_dir;
  assign mem_addr             = r_mem_addr;
  assign mem_we               = r_mem_we;
  assign mem_re               = r_mem_re;

endmodule

// File: tb/tb_fft_io_sequencer.sv
// Testbench for fft_io_sequencer: a 64-point instance with a small frame
// buffer / I/O stage model, plus a 2-point instance checked against a
// hand-written cycle table.
module tb_fft_io_sequencer;

  localparam int DW = 16;
  localparam int AW = 6;
  localparam int NP = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;

  logic start_load, start_unload, ext_valid;
  logic ext_strobe, ext_dir, busy, load_done, unload_done, cmd_err;
  logic cs, ew, ti, to, mem_we, mem_re;
  logic [AW-1:0] mem_addr;

  logic sl_s, su_s, ev_s;
  logic strobe_s, dir_s, busy_s, ld_s, ud_s, err_s, cs_s, ew_s, ti_s, to_s, we_s, re_s;
  logic [0:0] addr_s;

  fft_io_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_POINTS(NP)) dut (
    .io_clock(clk), .reset(rst_n),
    .start_load(start_load), .start_unload(start_unload), .ext_valid(ext_valid),
    .ext_strobe(ext_strobe), .ext_dir(ext_dir), .busy(busy),
    .load_done(load_done), .unload_done(unload_done), .cmd_err(cmd_err),
    .c_chip_select(cs), .c_ext_write(ew),
    .c_tri_data_2b_input(ti), .c_tri_data_2b_output(to),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re)
  );

  fft_io_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(1), .NUM_POINTS(2)) dut2 (
    .io_clock(clk), .reset(rst_n),
    .start_load(sl_s), .start_unload(su_s), .ext_valid(ev_s),
    .ext_strobe(strobe_s), .ext_dir(dir_s), .busy(busy_s),
    .load_done(ld_s), .unload_done(ud_s), .cmd_err(err_s),
    .c_chip_select(cs_s), .c_ext_write(ew_s),
    .c_tri_data_2b_input(ti_s), .c_tri_data_2b_output(to_s),
    .mem_addr(addr_s), .mem_we(we_s), .mem_re(re_s)
  );

  // Frame buffer and I/O stage data latch model.
  logic [DW-1:0] host_data;
  logic [DW-1:0] ram [NP];
  logic [DW-1:0] rdata;
  logic [DW-1:0] io_latch;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= io_latch;
    if (mem_re) rdata <= ram[mem_addr];
    if (cs) io_latch <= ew ? rdata : host_data;
  end

  // Output vector: busy strobe dir ld ud err cs ew ti to we re addr[5:0].
  logic [17:0] w_outs;
  assign w_outs = {busy, ext_strobe, ext_dir, load_done, unload_done, cmd_err,
                   cs, ew, ti, to, mem_we, mem_re, mem_addr};
  localparam logic [31:0] RST_VEC = 32'h0000_0300;

  int n_checks = 0;
  int n_fail = 0;
  int viol = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Exclusivity: never read and write together; internal bus only on writes.
  always @(negedge clk) begin
    #3;
    if (mem_we && mem_re) viol++;
    if (!ti && !mem_we) viol++;
    if (we_s && re_s) viol++;
    if (!ti_s && !we_s) viol++;
  end

  task automatic do_load(input logic [15:0] base, input bit gappy, input bit both,
                         input int inject_at);
    int  nacc, nwr, bad_cs, bad_wr, bad_ld, bad_ram;
    bit  prev_acc, done_seen, exp_cs;
    nacc = 0; nwr = 0; bad_cs = 0; bad_wr = 0; bad_ld = 0; bad_ram = 0;
    prev_acc = 1'b0; done_seen = 1'b0;
    @(negedge clk);
    start_load = 1'b1; start_unload = both; ext_valid = 1'b0;
    for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
      @(negedge clk);
      start_load   = 1'b0;
      start_unload = (cyc == inject_at);
      ext_valid    = (nacc >= NP) ? 1'b1 : (gappy ? ((cyc % 4) != 2) : 1'b1);
      host_data    = base + nacc[15:0];
      #2;
      if (cyc == 0) begin
        check("ld_err_start", cmd_err, both);
        check("ld_busy", busy, 1);
        check("ld_dir", ext_dir, 0);
      end
      if (inject_at >= 0 && cyc == inject_at + 1) check("ld_err_busy", cmd_err, 1);
      if (inject_at >= 0 && cyc == inject_at + 2) check("ld_err_pulse", cmd_err, 0);
      exp_cs = (nacc < NP) && ext_valid;
      if (cs !== exp_cs) bad_cs++;
      if (mem_we) begin
        if (mem_addr !== nwr[AW-1:0] || !prev_acc) bad_wr++;
        if (load_done !== (nwr == NP - 1)) bad_ld++;
        nwr++;
      end else if (load_done) begin
        bad_ld++;
      end
      if (load_done) done_seen = 1'b1;
      prev_acc = exp_cs;
      if (exp_cs) nacc++;
    end
    check("ld_done_seen", done_seen, 1);
    check("ld_writes", nwr, NP);
    check("ld_cs_track", bad_cs, 0);
    check("ld_wr_addr", bad_wr, 0);
    check("ld_done_pos", bad_ld, 0);
    @(negedge clk);
    ext_valid = 1'b0; start_unload = 1'b0;
    #2;
    check("ld_idle", {busy, mem_we, ti}, 3'b001);
    for (int k = 0; k < NP; k++)
      if (ram[k] !== base + 16'(k)) bad_ram++;
    check("ld_ram", bad_ram, 0);
  endtask

  task automatic do_unload(input logic [15:0] base);
    int bad_re, bad_st, bad_dat, bad_ud, bad_to, nst;
    bit exp_re, exp_st, exp_ud;
    logic [15:0] exp_w;
    bad_re = 0; bad_st = 0; bad_dat = 0; bad_ud = 0; bad_to = 0; nst = 0;
    @(negedge clk);
    start_unload = 1'b1;
    for (int cyc = 0; cyc <= NP + 3; cyc++) begin
      @(negedge clk);
      start_unload = 1'b0;
      #2;
      exp_re = (cyc < NP);
      if (mem_re !== exp_re || (exp_re && mem_addr !== cyc[AW-1:0])) bad_re++;
      exp_st = (cyc >= 2) && (cyc <= NP + 1);
      if (ext_strobe !== exp_st) bad_st++;
      if (ext_strobe) begin
        nst++;
        exp_w = base + 16'(cyc - 2);
        if (io_latch !== exp_w) bad_dat++;
      end
      exp_ud = (cyc == NP + 2);
      if (unload_done !== exp_ud) bad_ud++;
      if (cyc <= NP + 1 && to !== 1'b0) bad_to++;
      if (cyc == 0) check("ul_entry", {to, ext_dir, ew, mem_re}, 4'b0111);
      if (cyc == 1) check("ul_cs_first", {cs, ext_strobe}, 2'b10);
      if (cyc == 2) check("ul_first_strobe", ext_strobe, 1);
      if (cyc == NP + 2) check("ul_end", {unload_done, to, ext_dir, ew, busy}, 5'b11000);
    end
    check("ul_reads", bad_re, 0);
    check("ul_strobe_pos", bad_st, 0);
    check("ul_strobes", nst, NP);
    check("ul_data", bad_dat, 0);
    check("ul_done_pos", bad_ud, 0);
    check("ul_tri_out", bad_to, 0);
  endtask

  initial begin
    logic [7:0] exp2 [11];
    logic [2:0] in2  [11];
    logic       a2   [11];

    start_load = 1'b0; start_unload = 1'b0; ext_valid = 1'b0; host_data = '0;
    sl_s = 1'b0; su_s = 1'b0; ev_s = 1'b0;

    // 1: reset held three cycles, requests ignored
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ext_valid  = (i == 1);
      start_load = (i == 2);
      #2;
      check("rst_hold", w_outs, RST_VEC);
    end
    @(negedge clk);
    rst_n = 1'b1; ext_valid = 1'b0; start_load = 1'b0;

    // 2: gappy load 0x0000..
    do_load(16'h0000, 1'b1, 1'b0, -1);

    // 3: dense load 0x1000.., then unload it
    do_load(16'h1000, 1'b0, 1'b0, -1);
    do_unload(16'h1000);

    // 4: simultaneous starts in IDLE and an unload request mid-load
    do_load(16'h2000, 1'b1, 1'b1, 10);

    // 5: reset after 20 accepts, then fresh load
    @(negedge clk);
    start_load = 1'b1;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      start_load = 1'b0; ext_valid = 1'b1; host_data = 16'h4000 + 16'(i);
    end
    #2;
    check("mid_pre_rst", {busy, mem_we}, 2'b11);
    rst_n = 1'b0;
    #1;
    check("rst_mid", w_outs, RST_VEC);
    @(negedge clk);
    rst_n = 1'b1; ext_valid = 1'b0;
    #2;
    check("rst_mid_idle", {busy, load_done}, 2'b00);
    do_load(16'h3000, 1'b1, 1'b0, -1);

    // 6: 2-point instance, load then unload; {busy,we,re,cs,strobe,ld,ud,dir}
    in2  = '{3'b100, 3'b001, 3'b001, 3'b001, 3'b010, 3'b000,
             3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    exp2 = '{8'h00, 8'h90, 8'hD0, 8'hC4, 8'h00, 8'hA1,
             8'hB1, 8'h99, 8'h89, 8'h02, 8'h00};
    a2   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
             1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      {sl_s, su_s, ev_s} = in2[i];
      #2;
      check($sformatf("n2_ctl_c%0d", i),
            {busy_s, we_s, re_s, cs_s, strobe_s, ld_s, ud_s, dir_s}, exp2[i]);
      if (we_s || re_s) check($sformatf("n2_addr_c%0d", i), addr_s, a2[i]);
    end

    @(negedge clk);
    #4;
    check("exclusivity", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
